vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 1024x768 timing controller: generates hcount/vcount, hsync/vsync, hblnk/vblnk for any VESA-style mode given as active/front-porch/sync/back-porch parameters.
- Adds pixel clock-enable, per-parameter sync polarity, data-enable, line/frame start strobes and a frame counter.
- Sits at the head of the video pipeline and feeds the draw/overlay stages.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- HSYNC_POL, 1, hsync active level (1 = active-high)
- VSYNC_POL, 1, vsync active level
- CNT_W, 12, width of hcount/vcount
- FRAME_W, 8, width of frame_cnt

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  synchronous reset, active-low
- pix_en  in  1  advance enable; counters and outputs hold when 0
- hcount  out  CNT_W  pixel index in line
- vcount  out  CNT_W  line index in frame
- hsync  out  1  horizontal sync at HSYNC_POL level
- vsync  out  1  vertical sync at VSYNC_POL level
- hblnk  out  1  horizontal blanking
- vblnk  out  1  vertical blanking
- de  out  1  active video, equal to ~hblnk & ~vblnk
- line_start  out  1  one-clk strobe, hcount just became 0
- frame_start  out  1  one-clk strobe, hcount and vcount just became 0
- frame_cnt  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W
- irq_line  in  CNT_W  compare line (VGA_TIMING_LINE_IRQ_EN only)
- line_irq  out  1  compare strobe (VGA_TIMING_LINE_IRQ_EN only)

Behaviour:
- H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344). V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- Elaboration error if H_TOT or V_TOT does not fit in CNT_W bits.
- All outputs are registered. Every output is decoded from the *next* count value, so each output is consistent with the hcount/vcount presented in the same cycle (zero skew).
- On a clk edge with rst_n=1 and pix_en=1:
  - hcount = (hcount==H_TOT-1) ? 0 : hcount+1.
  - vcount advances only when hcount wraps: (vcount==V_TOT-1) ? 0 : vcount+1.
- pix_en=0: counts, syncs, blanks and de hold their values; line_start, frame_start and line_irq are driven 0. Strobes never repeat while stalled.
- hblnk=1 iff hcount >= H_ACTIVE.
- hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC. Default: 1048..1183.
- vblnk=1 iff vcount >= V_ACTIVE.
- vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. Default: 771..776. vsync is a full-line signal and changes only together with hcount becoming 0.
- line_start=1 for exactly the clk in which hcount has just advanced to 0.
- frame_start=1 for the clk in which both counts have just advanced to 0. On that same edge frame_cnt increments, 2^FRAME_W-1 wraps to 0.
- Reset (rst_n=0 at edge): hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0, frame_cnt=0, line_irq=0.
- Reset dominates pix_en. Reset mid-frame restarts at (0,0) on the next edge, with no frame_start strobe for the restart.
- The first frame_start occurs at the first natural wrap from (H_TOT-1, V_TOT-1).

Optional Feature:
- Macro VGA_TIMING_LINE_IRQ_EN.
- Defined:
  - irq_line is sampled into a shadow register only on frame_start edges (and on reset, shadow = 0).
  - line_irq is a one-clk strobe coincident with line_start when the new vcount equals the shadow.
  - If the shadow is >= V_TOT, line_irq never fires.
- Undefined: irq_line port absent; line_irq port absent; no shadow register.

Test Plan:
- Defaults, pix_en=1, run 2 frames -> hcount period 1344 clks; vcount period 806 lines; hsync high for hcount 1048..1183; vsync high for vcount 771..776; de high for exactly 1024x768 clks per frame.
- pix_en toggled 1/0 every clk -> same sequence at half rate; outputs stable during 0 cycles; exactly one line_start per line.
- HSYNC_POL=0, VSYNC_POL=0 -> after reset hsync=vsync=1; low only in the sync windows above.
- rst_n=0 for 1 clk at (500,400) -> next cycle (0,0), de=1, frame_cnt=0, frame_start stays 0 until (H_TOT-1, V_TOT-1) wraps.
- FRAME_W=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1, each change coincident with frame_start.
- VGA_TIMING_LINE_IRQ_EN, irq_line=10 then changed to 20 mid-frame -> line_irq at vcount=10 this frame and at vcount=20 next frame. irq_line=900 -> no line_irq.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VESA-style raster timing generator.
// Produces pixel/line counters, sync, blanking and data-enable for any mode
// given as active/front-porch/sync/back-porch parameters. The pipeline
// advances only on cycles with pix_en=1. All outputs are registered and
// decoded from the next count value, so they line up with hcount/vcount.
//
// Optional feature: define VGA_TIMING_LINE_IRQ_EN to add irq_line/line_irq,
// a per-frame programmable line-compare strobe.
//
// Ports:
//   clk          pixel-domain clock
//   rst_n        synchronous reset, active-low (dominates pix_en)
//   pix_en       advance enable; counts/syncs/blanks hold when 0
//   hcount       pixel index in line
//   vcount       line index in frame
//   hsync/vsync  sync pulses at HSYNC_POL/VSYNC_POL active level
//   hblnk/vblnk  horizontal/vertical blanking
//   de           active video (~hblnk & ~vblnk)
//   line_start   one-clk strobe, hcount just became 0
//   frame_start  one-clk strobe, hcount and vcount just became 0
//   frame_cnt    completed-frame count, wraps modulo 2^FRAME_W
//   irq_line     compare line, latched at frame start (macro only)
//   line_irq     strobe with line_start when vcount matches (macro only)
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 1024,
  parameter int unsigned H_FP      = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BP      = 160,
  parameter int unsigned V_ACTIVE  = 768,
  parameter int unsigned V_FP      = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 29,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [CNT_W-1:0]   irq_line,
  output logic               line_irq,
`endif
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;
  localparam longint unsigned CNT_RANGE = 64'(1) << CNT_W;

  // Totals must be representable so the last count H_TOT-1 / V_TOT-1 fits.
  if (64'(H_TOT) > CNT_RANGE) begin : g_h_tot_too_wide
    $error("vga_timing_gen: H_TOT does not fit in CNT_W bits");
  end
  if (64'(V_TOT) > CNT_RANGE) begin : g_v_tot_too_wide
    $error("vga_timing_gen: V_TOT does not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             hblnk_nxt;
  logic             vblnk_nxt;
  logic             hs_win;
  logic             vs_win;

  // Next-count computation and decode from the next value (zero skew).
  always_comb begin
    h_wrap    = (hcount == CNT_W'(H_TOT - 1));
    v_wrap    = (vcount == CNT_W'(V_TOT - 1));
    h_nxt     = h_wrap ? '0 : hcount + CNT_W'(1);
    v_nxt     = vcount;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : vcount + CNT_W'(1);
    end
    hblnk_nxt = (h_nxt >= CNT_W'(H_ACTIVE));
    vblnk_nxt = (v_nxt >= CNT_W'(V_ACTIVE));
    hs_win    = (h_nxt >= CNT_W'(HS_START)) && (h_nxt < CNT_W'(HS_END));
    vs_win    = (v_nxt >= CNT_W'(VS_START)) && (v_nxt < CNT_W'(VS_END));
  end

  // Counter and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      de          <= 1'b1;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (pix_en) begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= hblnk_nxt;
      vblnk       <= vblnk_nxt;
      de          <= ~hblnk_nxt & ~vblnk_nxt;
      hsync       <= hs_win ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_win ? VSYNC_POL : ~VSYNC_POL;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
      if (h_wrap && v_wrap) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end else begin
      // Stalled: levels hold, strobes must not repeat.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [CNT_W-1:0] irq_shadow;

  // Compare uses the shadow held before this edge; a new irq_line value
  // latched at frame start applies from the following line_start on.
  // A shadow >= V_TOT can never equal v_nxt, so it never fires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_shadow <= '0;
      line_irq   <= 1'b0;
    end else if (pix_en) begin
      line_irq <= h_wrap & (v_nxt == irq_shadow);
      if (h_wrap && v_wrap) begin
        irq_shadow <= irq_line;
      end
    end else begin
      line_irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen using a reduced
// mode (32x20 total) so many frames fit in a short run. Two instances share
// stimulus: one with active-high syncs, one with active-low syncs. Expected
// values come from a raster-position model (linear pixel index in a frame).
module tb_vga_timing_gen;

  localparam int unsigned HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int unsigned VA = 12, VF = 2, VS = 3, VB = 3;
  localparam int unsigned CW = 6, FW = 2;
  localparam int HT   = HA + HF + HS + HB;
  localparam int VT   = VA + VF + VS + VB;
  localparam int FTOT = HT * VT;

  logic          clk;
  logic          rst_n;
  logic          pix_en;
  logic [CW-1:0] hcount, vcount, hcount_n, vcount_n;
  logic          hsync, vsync, hblnk, vblnk, de, line_start, frame_start;
  logic          hsync_n, vsync_n, hblnk_n, vblnk_n, de_n, line_start_n, frame_start_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [CW-1:0] irq_line;
  logic          line_irq, line_irq_n;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(CW), .FRAME_W(FW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblnk(hblnk), .vblnk(vblnk), .de(de),
    .line_start(line_start), .frame_start(frame_start),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .irq_line(irq_line), .line_irq(line_irq),
`endif
    .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CW), .FRAME_W(FW)
  ) u_dut_n (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(hcount_n), .vcount(vcount_n), .hsync(hsync_n), .vsync(vsync_n),
    .hblnk(hblnk_n), .vblnk(vblnk_n), .de(de_n),
    .line_start(line_start_n), .frame_start(frame_start_n),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .irq_line(irq_line), .line_irq(line_irq_n),
`endif
    .frame_cnt(frame_cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: linear position in the frame plus strobe expectations.
  int p      = 0;
  int fc     = 0;
  int shadow = 0;
  bit e_ls   = 0;
  bit e_fs   = 0;
  bit e_irq  = 0;

  // Per-window counters of observed levels.
  int c_de, c_ls, c_hs, c_vs, c_fs;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    int h, v;
    bit hb, vb, hsa, vsa;
    h   = p % HT;
    v   = p / HT;
    hb  = (h >= HA);
    vb  = (v >= VA);
    hsa = (h >= HA + HF) && (h < HA + HF + HS);
    vsa = (v >= VA + VF) && (v < VA + VF + VS);
    chk("hcount", int'(hcount), h);
    chk("vcount", int'(vcount), v);
    chk("hblnk", int'(hblnk), int'(hb));
    chk("vblnk", int'(vblnk), int'(vb));
    chk("de", int'(de), int'(!hb && !vb));
    chk("hsync", int'(hsync), int'(hsa));
    chk("vsync", int'(vsync), int'(vsa));
    chk("line_start", int'(line_start), int'(e_ls));
    chk("frame_start", int'(frame_start), int'(e_fs));
    chk("frame_cnt", int'(frame_cnt), fc);
    chk("n_hcount", int'(hcount_n), h);
    chk("n_vcount", int'(vcount_n), v);
    chk("n_hsync", int'(hsync_n), int'(!hsa));
    chk("n_vsync", int'(vsync_n), int'(!vsa));
    chk("n_hblnk", int'(hblnk_n), int'(hb));
    chk("n_vblnk", int'(vblnk_n), int'(vb));
    chk("n_de", int'(de_n), int'(!hb && !vb));
    chk("n_line_start", int'(line_start_n), int'(e_ls));
    chk("n_frame_start", int'(frame_start_n), int'(e_fs));
    chk("n_frame_cnt", int'(frame_cnt_n), fc);
`ifdef VGA_TIMING_LINE_IRQ_EN
    chk("line_irq", int'(line_irq), int'(e_irq));
    chk("n_line_irq", int'(line_irq_n), int'(e_irq));
`endif
  endtask

  // One clock: drive inputs, advance model, compare after the edge.
  task automatic step(input logic r, input logic e);
    int irq_smp;
    rst_n  = r;
    pix_en = e;
    irq_smp = 0;
`ifdef VGA_TIMING_LINE_IRQ_EN
    irq_smp = int'(irq_line);
`endif
    @(posedge clk);
    #1;
    if (!r) begin
      p = 0; fc = 0; shadow = 0; e_ls = 0; e_fs = 0; e_irq = 0;
    end else if (e) begin
      p     = (p + 1) % FTOT;
      e_ls  = (p % HT == 0);
      e_fs  = (p == 0);
      e_irq = e_ls && ((p / HT) == shadow);
      if (e_fs) begin
        fc     = (fc + 1) % (1 << FW);
        shadow = irq_smp;
      end
    end else begin
      e_ls = 0; e_fs = 0; e_irq = 0;
    end
    check_outputs();
    if (de) c_de++;
    if (line_start) c_ls++;
    if (hsync) c_hs++;
    if (vsync) c_vs++;
    if (frame_start) c_fs++;
    @(negedge clk);
  endtask

  task automatic clr_counts();
    c_de = 0; c_ls = 0; c_hs = 0; c_vs = 0; c_fs = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;
`ifdef VGA_TIMING_LINE_IRQ_EN
    irq_line = CW'(5);
`endif
    @(negedge clk);

    // Reset, with and without pix_en.
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Two full frames at full rate; per-frame level counts.
    for (int f = 0; f < 2; f++) begin
      clr_counts();
      for (int k = 0; k < FTOT; k++) step(1'b1, 1'b1);
      chk("de_per_frame", c_de, HA * VA);
      chk("ls_per_frame", c_ls, VT);
      chk("hs_per_frame", c_hs, HS * VT);
      chk("vs_per_frame", c_vs, VS * HT);
      chk("fs_per_frame", c_fs, 1);
    end

`ifdef VGA_TIMING_LINE_IRQ_EN
    irq_line = CW'(10);
`endif
    // Half-rate enable: one frame of advance over 2*FTOT clocks.
    clr_counts();
    for (int k = 0; k < 2 * FTOT; k++) step(1'b1, logic'(k % 2 == 0));
    chk("ls_half_rate", c_ls, VT);
    chk("fs_half_rate", c_fs, 1);

`ifdef VGA_TIMING_LINE_IRQ_EN
    // Change compare line mid-frame; old value must apply to this frame.
    for (int k = 0; k < FTOT / 2; k++) step(1'b1, 1'b1);
    irq_line = CW'(17);
    for (int k = 0; k < 2 * FTOT; k++) step(1'b1, 1'b1);
    irq_line = CW'(VT + 3);
    for (int k = 0; k < 2 * FTOT; k++) step(1'b1, 1'b1);
`endif

    // Reset mid-frame at a chosen raster position.
    begin
      int target;
      target = 9 * HT + 20;
      for (int k = 0; k < FTOT && p != target; k++) step(1'b1, 1'b1);
      chk("reach_target", p, target);
    end
    step(1'b0, 1'b1);
    clr_counts();
    for (int k = 0; k < FTOT - 1; k++) step(1'b1, 1'b1);
    chk("no_fs_before_wrap", c_fs, 0);
    step(1'b1, 1'b1);
    chk("fs_at_wrap", c_fs, 1);

    // Five frames to exercise frame_cnt wrap at 2^FW.
    for (int k = 0; k < 5 * FTOT; k++) step(1'b1, 1'b1);

    // Random enable, sparse resets, random compare line.
    for (int k = 0; k < 4000; k++) begin
`ifdef VGA_TIMING_LINE_IRQ_EN
      if ($urandom_range(0, 99) == 0) irq_line = CW'($urandom_range(0, VT + 3));
`endif
      step(logic'($urandom_range(0, 499) != 0), logic'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
